// File: rtl/matrix_sram_loader.sv
// matrix_sram_loader: writes a header+row-major matrix word stream into SRAM at addresses 0..N
module matrix_sram_loader #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4096
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  sram_write_enable,
   output logic [ADDR_WIDTH-1:0] sram_write_address,
   output logic [DATA_WIDTH-1:0] sram_write_data,
   output logic                  busy,
   output logic                  load_done,
   output logic                  load_error,
   output logic [ADDR_WIDTH-1:0] element_count
);
   typedef enum logic [1:0] {IDLE, HEADER, DATA, DONE} state_t;
   state_t state;
   logic [31:0] total;
   logic [31:0] prod;
   logic xfer;
   logic hdr_bad;
   assign in_ready = (state == HEADER) || (state == DATA);
   assign busy     = state != IDLE;
   assign xfer     = in_valid && in_ready;
   assign prod     = 32'(in_data[31:16]) * 32'(in_data[15:0]);
   assign hdr_bad  = ~|in_data[31:16] || ~|in_data[15:0] || (prod > 32'(DEPTH - 1));
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state              <= IDLE;
         total              <= '0;
         sram_write_enable  <= 1'b0;
         sram_write_address <= '0;
         sram_write_data    <= '0;
         load_done          <= 1'b0;
         load_error         <= 1'b0;
         element_count      <= '0;
      end else begin
         sram_write_enable <= 1'b0;
         load_done         <= 1'b0;
         if (abort) state <= IDLE;
         else begin
            case (state)
               IDLE: if (start) begin
                  state         <= HEADER;
                  load_error    <= 1'b0;
                  element_count <= '0;
               end
               HEADER: if (xfer) begin
                  sram_write_enable  <= 1'b1;
                  sram_write_address <= '0;
                  sram_write_data    <= in_data;
                  total              <= prod;
                  load_error         <= hdr_bad;
                  load_done          <= hdr_bad;
                  state              <= hdr_bad ? DONE : DATA;
               end
               DATA: if (xfer) begin
                  sram_write_enable  <= 1'b1;
                  sram_write_address <= element_count + ADDR_WIDTH'(1);
                  sram_write_data    <= in_data;
                  element_count      <= element_count + ADDR_WIDTH'(1);
                  load_done          <= 32'(element_count) == total - 32'd1;
                  state              <= (32'(element_count) == total - 32'd1) ? DONE : DATA;
               end
               DONE: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_matrix_sram_loader.sv
// tb_matrix_sram_loader: table-driven and directed checks of the SRAM loader (DEPTH=16)
module tb_matrix_sram_loader;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [31:0] in_data = '0;
   logic sram_write_enable;
   logic [15:0] sram_write_address;
   logic [31:0] sram_write_data;
   logic busy;
   logic load_done;
   logic load_error;
   logic [15:0] element_count;
   int errors = 0;
   int checks = 0;
   logic [15:0] wa[$];
   logic [31:0] wd[$];
   int wc[$];
   int cyc = 0;
   int done_cnt = 0;
   logic done_wr = 1'b0;
   logic [15:0] done_addr = '0;
   typedef struct {
      logic [31:0] hdr;
      int          n_wr;
      logic        err;
      int          cnt;
   } rec_t;
   rec_t tbl[9];
   matrix_sram_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .sram_write_enable(sram_write_enable), .sram_write_address(sram_write_address),
      .sram_write_data(sram_write_data), .busy(busy), .load_done(load_done),
      .load_error(load_error), .element_count(element_count)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      cyc++;
      if (sram_write_enable) begin
         wa.push_back(sram_write_address);
         wd.push_back(sram_write_data);
         wc.push_back(cyc);
      end
      if (load_done) begin
         done_cnt++;
         done_wr   = sram_write_enable;
         done_addr = sram_write_address;
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic clear_mon();
      wa.delete();
      wd.delete();
      wc.delete();
      done_cnt = 0;
      done_wr = 1'b0;
      done_addr = '0;
   endtask
   task automatic send(input logic [31:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_data = d;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask
   task automatic run_load(input logic [31:0] hdr, input int n_el);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_err_clr", 32'(load_error), 32'd0);
      chk("start_cnt_clr", 32'(element_count), 32'd0);
      send(hdr);
      for (int i = 0; i < n_el; i++) send(32'hA000_0000 + 32'(i));
      repeat (3) @(posedge clk);
      #1;
   endtask
   task automatic verify_writes(input logic [31:0] hdr, input int n_wr, input int gap);
      chk("wr_count", 32'(wa.size()), 32'(n_wr));
      for (int i = 0; i < n_wr && i < wa.size(); i++) begin
         chk("wr_addr", 32'(wa[i]), 32'(i));
         chk("wr_data", wd[i], i == 0 ? hdr : 32'hA000_0000 + 32'(i - 1));
         chk("wr_spacing", 32'(wc[i] - wc[0]), 32'(i * gap));
      end
   endtask
   initial begin
      tbl[0] = '{32'h0002_0003, 7, 1'b0, 6};
      tbl[1] = '{32'h0000_0004, 1, 1'b1, 0};
      tbl[2] = '{32'h0001_0002, 3, 1'b0, 2};
      tbl[3] = '{32'h0004_0000, 1, 1'b1, 0};
      tbl[4] = '{32'h0004_0004, 1, 1'b1, 0};
      tbl[5] = '{32'h0003_0005, 16, 1'b0, 15};
      tbl[6] = '{32'hFFFF_FFFF, 1, 1'b1, 0};
      tbl[7] = '{32'h0001_0001, 2, 1'b0, 1};
      tbl[8] = '{32'h0001_0010, 1, 1'b1, 0};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_we", 32'(sram_write_enable), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(load_done), 32'd0);
      chk("rst_err", 32'(load_error), 32'd0);
      chk("rst_addr", 32'(sram_write_address), 32'd0);
      chk("rst_data", sram_write_data, 32'd0);
      chk("rst_cnt", 32'(element_count), 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      chk("idle_abort_over_start", 32'(busy), 32'd0);
      start = 1'b0;
      abort = 1'b0;
      for (int t = 0; t < 9; t++) begin
         clear_mon();
         run_load(tbl[t].hdr, tbl[t].n_wr - 1);
         verify_writes(tbl[t].hdr, tbl[t].n_wr, 1);
         chk("tbl_err", 32'(load_error), 32'(tbl[t].err));
         chk("tbl_cnt", 32'(element_count), 32'(tbl[t].cnt));
         chk("tbl_done_cnt", 32'(done_cnt), 32'd1);
         chk("tbl_done_with_wr", 32'(done_wr), 32'd1);
         chk("tbl_done_addr", 32'(done_addr), 32'(tbl[t].n_wr - 1));
         chk("tbl_idle", 32'(busy), 32'd0);
      end
      clear_mon();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data = i == 0 ? 32'h0002_0002 : 32'hA000_0000 + 32'(i - 1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         start = i == 2;
         @(posedge clk); #1;
         start = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      verify_writes(32'h0002_0002, 5, 2);
      chk("bubble_cnt", 32'(element_count), 32'd4);
      chk("bubble_done_cnt", 32'(done_cnt), 32'd1);
      chk("bubble_done_addr", 32'(done_addr), 32'd4);
      chk("bubble_idle", 32'(busy), 32'd0);
      clear_mon();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      send(32'h0002_0003);
      for (int i = 0; i < 3; i++) send(32'hA000_0000 + 32'(i));
      in_valid = 1'b1;
      in_data = 32'hDEAD_BEEF;
      abort = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_no_we", 32'(sram_write_enable), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      verify_writes(32'h0002_0003, 4, 1);
      chk("abort_cnt", 32'(element_count), 32'd3);
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      chk("abort_err", 32'(load_error), 32'd0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      send(32'h0002_0003);
      send(32'hA000_0000);
      send(32'hA000_0001);
      in_valid = 1'b1;
      in_data = 32'h1234_5678;
      reset_n = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("mrst_in_ready", 32'(in_ready), 32'd0);
      chk("mrst_we", 32'(sram_write_enable), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(load_done), 32'd0);
      chk("mrst_addr", 32'(sram_write_address), 32'd0);
      chk("mrst_data", sram_write_data, 32'd0);
      chk("mrst_cnt", 32'(element_count), 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      clear_mon();
      run_load(32'h0001_0002, 2);
      verify_writes(32'h0001_0002, 3, 1);
      chk("reload_cnt", 32'(element_count), 32'd2);
      chk("reload_done", 32'(done_cnt), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
